// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and types for the register-file write-back path.
//   DW/AW/N_REGS : data width, address width, implemented register count
//   rf_addr_t    : register address
//   rf_data_t    : register data
//   wb_state_e   : write-port owner state (INIT clears the file, RUN arbitrates)
package rf_pkg;
  localparam int DW     = 48;
  localparam int AW     = 4;
  localparam int N_REGS = 14;

  typedef logic [AW-1:0] rf_addr_t;
  typedef logic [DW-1:0] rf_data_t;

  typedef enum logic {INIT, RUN} wb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: generic N-way round-robin priority pick, purely combinational.
//   req_i : request vector
//   ptr_i : index with highest priority this cycle; search goes upward with wrap
//   gnt_o : one-hot grant, zero when no request
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  logic found;

  // k is the distance from ptr_i; the first requester hit wins
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req_i[i] && (i == (int'(ptr_i) + k) % N)) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: owns the register-file write port (we3/ra3/wd3).
//   After reset, clears every register through the port (INIT), then shares the
//   port between N_REQ write-back requesters round-robin (RUN). Also keeps a
//   per-register pending-write scoreboard for RAW stall checks at issue.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   req_valid/req_addr/req_data    per-requester write requests (req 0 in LSBs)
//   req_ready                      per-requester accept (one-hot or zero)
//   rf_we/rf_waddr/rf_wdata        register-file write port
//   rsv_valid/rsv_addr, rsv_err    destination reservation, illegal-reservation pulse
//   chk_addr1/2, chk_busy1/2       source pending-write queries
//   wr_err                         pulse: accepted write to an unimplemented register
//   init_done                      clear sequence complete
module rf_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DW     = rf_pkg::DW,
  parameter int AW     = rf_pkg::AW,
  parameter int N_REGS = rf_pkg::N_REGS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                rf_we,
  output logic [AW-1:0]       rf_waddr,
  output logic [DW-1:0]       rf_wdata,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_err,
  input  logic [AW-1:0]       chk_addr1,
  input  logic [AW-1:0]       chk_addr2,
  output logic                chk_busy1,
  output logic                chk_busy2,
  output logic                wr_err,
  output logic                init_done
);
  import rf_pkg::*;

  localparam int PW = $clog2(N_REQ);
  localparam logic [AW-1:0] LAST_REG = AW'(N_REGS - 1);
  localparam logic [PW-1:0] LAST_REQ = PW'(N_REQ - 1);

  wb_state_e         state_q;
  logic [AW-1:0]     clr_cnt_q;
  logic [PW-1:0]     rr_ptr_q;
  logic [N_REGS-1:0] busy_q, busy_d, clr_mask;
  logic              rf_we_q, rsv_err_q, wr_err_q, init_done_q;
  logic [AW-1:0]     rf_waddr_q;
  logic [DW-1:0]     rf_wdata_q;

  logic [N_REQ-1:0]  gnt;
  logic [PW-1:0]     gidx;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_data;
  logic              run, xfer, rsv_bad;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt)
  );

  assign run       = (state_q == RUN);
  assign req_ready = run ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);

  // Mux the granted requester onto a single address/data path
  always_comb begin
    gidx     = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gidx     = PW'(i);
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Scoreboard: the write in flight clears first, so a same-cycle reservation of
  // that register is legal and leaves the bit set.
  always_comb begin
    clr_mask = '0;
    if (rf_we_q) clr_mask[rf_waddr_q] = 1'b1;
    busy_d  = busy_q & ~clr_mask;
    rsv_bad = 1'b0;
    if (run && rsv_valid) begin
      if (rsv_addr > LAST_REG || busy_d[rsv_addr]) rsv_bad = 1'b1;
      else                                         busy_d[rsv_addr] = 1'b1;
    end
  end

  assign chk_busy1 = (chk_addr1 <= LAST_REG) ? busy_q[chk_addr1] : 1'b0;
  assign chk_busy2 = (chk_addr2 <= LAST_REG) ? busy_q[chk_addr2] : 1'b0;

  // INIT drives the clear sweep straight from the counter so the first write
  // lands in the first cycle after reset.
  assign rf_we     = run ? rf_we_q    : 1'b1;
  assign rf_waddr  = run ? rf_waddr_q : clr_cnt_q;
  assign rf_wdata  = run ? rf_wdata_q : '0;
  assign rsv_err   = rsv_err_q;
  assign wr_err    = wr_err_q;
  assign init_done = init_done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT;
      clr_cnt_q   <= '0;
      rr_ptr_q    <= '0;
      busy_q      <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      rsv_err_q   <= 1'b0;
      wr_err_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      rsv_err_q <= rsv_bad;
      rf_we_q   <= 1'b0;
      wr_err_q  <= 1'b0;
      case (state_q)
        INIT: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_REG) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          if (xfer) begin
            rr_ptr_q <= (gidx == LAST_REQ) ? '0 : gidx + 1'b1;
            // Unimplemented targets are accepted but dropped
            if (sel_addr <= LAST_REG) begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= sel_addr;
              rf_wdata_q <= sel_data;
            end else begin
              wr_err_q   <= 1'b1;
            end
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  localparam int N_REQ = 3;
  localparam int DW    = 48;
  localparam int AW    = 4;

  localparam logic [DW-1:0] DA = 48'hA0A0_A0A0_A0A0;
  localparam logic [DW-1:0] DB = 48'hB1B1_B1B1_B1B1;
  localparam logic [DW-1:0] DC = 48'hC2C2_C2C2_C2C2;
  localparam logic [DW-1:0] DD = 48'hD3D3_0000_D3D3;
  localparam logic [DW-1:0] DE = 48'hE4E4_1234_E4E4;
  localparam logic [DW-1:0] DF = 48'hF5F5_5678_F5F5;
  localparam logic [DW-1:0] Z  = '0;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_REQ-1:0]    req_valid, req_ready;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_data;
  logic                rf_we;
  logic [AW-1:0]       rf_waddr;
  logic [DW-1:0]       rf_wdata;
  logic                rsv_valid, rsv_err;
  logic [AW-1:0]       rsv_addr, chk_addr1, chk_addr2;
  logic                chk_busy1, chk_busy2, wr_err, init_done;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.N_REQ(N_REQ), .DW(DW), .AW(AW), .N_REGS(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_err(rsv_err),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .wr_err(wr_err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the edge, outputs are sampled 1 unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
    step();
    step();
    rst_n = 1'b1;
    // Requests and reservations during INIT must be ignored
    req_valid = '1; req_addr = {4'd3, 4'd2, 4'd1};
    rsv_valid = 1'b1; rsv_addr = 4'd3; chk_addr1 = 4'd3;
    for (int c = 0; c < 14; c++) begin
      #1;
      checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL init_we c=%0d got %b exp 1", c, rf_we); end
      checks++; if (rf_waddr !== 4'(c)) begin errors++; $display("FAIL init_waddr c=%0d got %0d exp %0d", c, rf_waddr, c); end
      checks++; if (rf_wdata !== Z) begin errors++; $display("FAIL init_wdata c=%0d got %h exp 0", c, rf_wdata); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_low c=%0d got %b exp 0", c, init_done); end
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL init_ready c=%0d got %b exp 000", c, req_ready); end
      checks++; if (rsv_err !== 1'b0 || wr_err !== 1'b0) begin errors++; $display("FAIL init_err c=%0d got %b%b exp 00", c, rsv_err, wr_err); end
      if (c == 13) begin req_valid = '0; rsv_valid = 1'b0; end
      step();
    end
    #1;
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_rise got %b exp 1", init_done); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL run_idle_we got %b exp 0", rf_we); end
    checks++; if (chk_busy1 !== 1'b0) begin errors++; $display("FAIL init_rsv_ignored got %b exp 0", chk_busy1); end
    checks++; if (rsv_err !== 1'b0) begin errors++; $display("FAIL init_rsv_noerr got %b exp 0", rsv_err); end
    step();
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] ea [3];
    logic [DW-1:0] ed [3];
    logic [N_REQ-1:0] er;
    int j;
    ea = '{4'd2, 4'd5, 4'd9};
    ed = '{DA, DB, DC};
    req_addr = {4'd9, 4'd5, 4'd2}; req_data = {DC, DB, DA}; req_valid = '1;
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) req_valid = '0;
      #1;
      er = (k == 6) ? 3'b000 : (3'b001 << (k % 3));
      checks++; if (req_ready !== er) begin errors++; $display("FAIL rr_ready k=%0d got %b exp %b", k, req_ready, er); end
      if (k >= 1) begin
        j = (k - 1) % 3;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL rr_we k=%0d got %b exp 1", k, rf_we); end
        checks++; if (rf_waddr !== ea[j]) begin errors++; $display("FAIL rr_waddr k=%0d got %0d exp %0d", k, rf_waddr, ea[j]); end
        checks++; if (rf_wdata !== ed[j]) begin errors++; $display("FAIL rr_wdata k=%0d got %h exp %h", k, rf_wdata, ed[j]); end
      end
      step();
    end
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rr_idle_we got %b exp 0", rf_we); end
    checks++; if (rf_waddr !== 4'd9 || rf_wdata !== DC) begin errors++; $display("FAIL rr_hold got %0d/%h exp 9/%h", rf_waddr, rf_wdata, DC); end
    step();
  endtask

  task automatic test_raw_waw();
    rsv_valid = 1'b1; rsv_addr = 4'd4; chk_addr1 = 4'd4;
    #1;
    checks++; if (chk_busy1 !== 1'b0) begin errors++; $display("FAIL raw_pre got %b exp 0", chk_busy1); end
    step();
    #1;
    checks++; if (chk_busy1 !== 1'b1) begin errors++; $display("FAIL raw_set got %b exp 1", chk_busy1); end
    checks++; if (rsv_err !== 1'b0) begin errors++; $display("FAIL raw_first_noerr got %b exp 0", rsv_err); end
    step();
    rsv_valid = 1'b0;
    req_valid = 3'b010; req_addr = {4'd0, 4'd4, 4'd0}; req_data = {Z, DD, Z};
    #1;
    checks++; if (rsv_err !== 1'b1) begin errors++; $display("FAIL waw_err got %b exp 1", rsv_err); end
    checks++; if (chk_busy1 !== 1'b1) begin errors++; $display("FAIL waw_keep got %b exp 1", chk_busy1); end
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL raw_ready got %b exp 010", req_ready); end
    step();
    req_valid = '0;
    #1;
    checks++; if (rsv_err !== 1'b0) begin errors++; $display("FAIL waw_pulse got %b exp 0", rsv_err); end
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd4 || rf_wdata !== DD) begin errors++; $display("FAIL raw_write got %b/%0d/%h exp 1/4/%h", rf_we, rf_waddr, rf_wdata, DD); end
    checks++; if (chk_busy1 !== 1'b1) begin errors++; $display("FAIL raw_busy_in_write got %b exp 1", chk_busy1); end
    step();
    #1;
    checks++; if (chk_busy1 !== 1'b0) begin errors++; $display("FAIL raw_clear got %b exp 0", chk_busy1); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL raw_we_drop got %b exp 0", rf_we); end
    step();
  endtask

  task automatic test_clear_vs_reserve();
    rsv_valid = 1'b1; rsv_addr = 4'd7; chk_addr2 = 4'd7;
    step();
    rsv_valid = 1'b0;
    req_valid = 3'b001; req_addr = {4'd0, 4'd0, 4'd7}; req_data = {Z, Z, DE};
    #1;
    checks++; if (chk_busy2 !== 1'b1) begin errors++; $display("FAIL cvr_set got %b exp 1", chk_busy2); end
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL cvr_ready_wrap got %b exp 001", req_ready); end
    step();
    req_valid = '0; rsv_valid = 1'b1; rsv_addr = 4'd7;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd7 || rf_wdata !== DE) begin errors++; $display("FAIL cvr_write got %b/%0d/%h exp 1/7/%h", rf_we, rf_waddr, rf_wdata, DE); end
    step();
    rsv_valid = 1'b0;
    #1;
    checks++; if (rsv_err !== 1'b0) begin errors++; $display("FAIL cvr_noerr got %b exp 0", rsv_err); end
    checks++; if (chk_busy2 !== 1'b1) begin errors++; $display("FAIL cvr_busy got %b exp 1", chk_busy2); end
    step();
  endtask

  task automatic test_out_of_range();
    req_valid = 3'b100; req_addr = {4'd14, 4'd0, 4'd0}; req_data = {48'hFFFF, Z, Z};
    chk_addr1 = 4'd14;
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL oor_ready got %b exp 100", req_ready); end
    checks++; if (chk_busy1 !== 1'b0) begin errors++; $display("FAIL oor_chk got %b exp 0", chk_busy1); end
    step();
    req_valid = '0; rsv_valid = 1'b1; rsv_addr = 4'd15;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL oor_we got %b exp 0", rf_we); end
    checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b exp 1", wr_err); end
    checks++; if (rf_waddr !== 4'd7) begin errors++; $display("FAIL oor_addr_hold got %0d exp 7", rf_waddr); end
    step();
    rsv_valid = 1'b0;
    #1;
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL oor_wr_pulse got %b exp 0", wr_err); end
    checks++; if (rsv_err !== 1'b1) begin errors++; $display("FAIL oor_rsv_err got %b exp 1", rsv_err); end
    checks++; if (chk_busy2 !== 1'b1) begin errors++; $display("FAIL oor_sb_untouched got %b exp 1", chk_busy2); end
    step();
  endtask

  task automatic test_reset_mid();
    // busy[7] is already set; add 4..6 to reach 0x00F0
    for (int r = 4; r <= 6; r++) begin
      rsv_valid = 1'b1; rsv_addr = 4'(r);
      step();
    end
    rsv_valid = 1'b0;
    chk_addr1 = 4'd4; chk_addr2 = 4'd7;
    req_valid = 3'b001; req_addr = {4'd0, 4'd0, 4'd3}; req_data = {Z, Z, DF};
    #1;
    checks++; if (chk_busy1 !== 1'b1 || chk_busy2 !== 1'b1) begin errors++; $display("FAIL mid_pre_busy got %b%b exp 11", chk_busy1, chk_busy2); end
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL mid_ready got %b exp 001", req_ready); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; req_valid = '0;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd0 || rf_wdata !== Z) begin errors++; $display("FAIL mid_restart got %b/%0d/%h exp 1/0/0", rf_we, rf_waddr, rf_wdata); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL mid_init_done got %b exp 0", init_done); end
    checks++; if (chk_busy1 !== 1'b0 || chk_busy2 !== 1'b0) begin errors++; $display("FAIL mid_busy_clr got %b%b exp 00", chk_busy1, chk_busy2); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL mid_ready_low got %b exp 000", req_ready); end
    step();
    repeat (13) step();
    // rr_ptr back at 0 grants requester 0 first; a surviving pointer of 1 would pick 2
    req_valid = 3'b101; req_addr = {4'd2, 4'd0, 4'd1}; req_data = {DB, Z, DA};
    #1;
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL mid_reinit_done got %b exp 1", init_done); end
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL mid_ptr_reset got %b exp 001", req_ready); end
    step();
    req_valid = '0;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd1 || rf_wdata !== DA) begin errors++; $display("FAIL mid_post_write got %b/%0d/%h exp 1/1/%h", rf_we, rf_waddr, rf_wdata, DA); end
    step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_raw_waw();
    test_clear_vs_reserve();
    test_out_of_range();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single write port (we3/ra3/wd3) of the 14x48-bit vector register file and shares it between N write-back requesters using round-robin arbitration.
- After reset it clears all 14 registers through that port before accepting any traffic.
- Keeps a per-register pending-write scoreboard; decode/issue queries it to stall on RAW hazards.
- Sits between the execute/load write-back stages and regFile.

Parameters:
- N_REQ, 3, number of write-back requesters (2..4)
- DW, 48, register data width
- AW, 4, register address width
- N_REGS, 14, number of implemented registers

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  N_REQ  per-requester write request
- req_addr  in  N_REQ*AW  per-requester destination register, packed, requester 0 in LSBs
- req_data  in  N_REQ*DW  per-requester write data, packed
- req_ready  out  N_REQ  per-requester accept, one-hot or zero
- rf_we  out  1  to regFile we3
- rf_waddr  out  AW  to regFile ra3
- rf_wdata  out  DW  to regFile wd3
- rsv_valid  in  1  issue reserves a destination register
- rsv_addr  in  AW  register being reserved
- rsv_err  out  1  1-cycle pulse: illegal reservation
- chk_addr1, chk_addr2  in  AW  source registers to check
- chk_busy1, chk_busy2  out  1  source has a pending write
- wr_err  out  1  1-cycle pulse: accepted write with addr >= N_REGS
- init_done  out  1  clear sequence complete

Behaviour:
- Clock: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values (next edge with rst_n=0): state=INIT, clr_cnt=0, rr_ptr=0, busy=0, rf_we=0, rf_waddr=0, rf_wdata=0, rsv_err=0, wr_err=0, init_done=0, req_ready=0.
- rst_n low mid-operation: at that edge, discard any in-flight write and any pending busy bits, then restart INIT.

FSM:
- INIT:
  - rf_we=1, rf_waddr=clr_cnt, rf_wdata=0, clr_cnt increments each cycle.
  - After address N_REGS-1 is driven, go to RUN; init_done=1 from the first RUN cycle.
  - INIT lasts exactly N_REGS cycles.
  - req_ready=0 throughout; rsv_valid is ignored with no error.
- RUN: arbitration as below. There is no return to INIT except by reset.

Arbitration (RUN):
- Search req_valid starting at index rr_ptr, upward with wrap.
- The first set bit i gets req_ready[i]=1, combinationally in the same cycle.
- Transfer occurs when req_valid[i] && req_ready[i].
- On a transfer, rr_ptr <= (i+1) mod N_REQ; with no transfer, rr_ptr holds.
- At most one grant per cycle.
- Requesters hold valid, addr and data stable until ready.
- Output stage is registered: a transfer in cycle t drives rf_we=1 with that addr/data in cycle t+1, and regFile commits at the end of t+1.
- With no transfer, rf_we=0 next cycle; addr/data hold their last values.
- Address >= N_REGS: the request is still accepted (ready asserted), rf_we stays 0 for it, wr_err pulses in t+1, and the scoreboard is untouched.

Scoreboard:
- busy[N_REGS-1:0] is a register.
- Set: rsv_valid && rsv_addr < N_REGS && !busy[rsv_addr] sets the bit at the next edge.
- Illegal reservation: rsv_addr >= N_REGS, or reserving an already-busy register (WAW), pulses rsv_err next cycle and leaves busy unchanged.
- Clear: the bit clears in the cycle rf_we=1 for that address, i.e. at the end of the write cycle.
- Same register cleared and reserved in the same cycle: reserve wins (bit stays 1), and no rsv_err is raised.
- chk_busyN = busy[chk_addrN] from registered state. There is no bypass of same-cycle writes.
- Out-of-range chk_addrN returns 0.

Decomposition:
- Package rf_pkg holds:
  - DW, AW, N_REGS constants
  - typedef rf_addr_t (logic [AW-1:0]) and rf_data_t (logic [DW-1:0])
  - enum wb_state_e {INIT, RUN}
- One sub-module, rr_arbiter: generic N-way round-robin with req, ptr and one-hot grant; purely combinational.
- Pointer register, FSM, output stage and scoreboard live in rf_wb_arbiter.

Test Plan:
- Reset then idle: rf_we=1 for 14 cycles with rf_waddr 0..13 and rf_wdata=0; init_done rises on cycle 15; req_ready=0 until then.
- All three requesters valid continuously, distinct addrs 2/5/9 with data A/B/C: grants go 0,1,2,0,1,2; each rf_we appears one cycle after its ready, with the matching addr/data.
- rsv_addr=4 then rsv_addr=4 again the next cycle: chk_busy1 (chk_addr1=4) =1; second reservation gives an rsv_err pulse; requester 1 writes reg 4, so busy clears after the rf_we cycle and chk_busy1=0 the following cycle.
- Same cycle, rf_we to reg 7 (busy) and rsv_addr=7: busy[7] remains 1 and rsv_err=0.
- Requester 2 writes addr 14 with data 0xFFFF: req_ready[2]=1, rf_we=0, and one wr_err pulse.
- rst_n low for one cycle while requester 0 is mid-transfer and busy=0x00F0: the next cycle shows rf_we/waddr=0 restarting INIT, busy=0, init_done=0, and rr_ptr=0.
